seven_seg_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller for the DE-board HEX displays. It latches a binary value through a load/busy handshake and renders it on NUM_DIGITS active-low displays in hexadecimal or decimal. Decimal conversion uses a sequential double-dabble engine. Features include leading-zero blanking, overflow indication and optional blinking. It replaces per-display combinational decoders at the top level of lab designs.

---
 rtl/seven_seg_display_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_seven_seg_display_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_ctrl.sv
// Multi-digit seven-segment display controller: latches a value on load, renders hex or decimal (double-dabble) glyphs.
// Latency: hex 1 cycle, decimal DATA_W+1 cycles from the load edge to the HEX update.
// Backpressure: busy is high while a load is processed; loads seen while busy are dropped. Optional blink via SEVENSEG_BLINK_EN.
module seven_seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic                    blink,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  // Decimal digits needed to hold 2^w - 1, i.e. ceil(w*log10(2)).
  function automatic int dec_digits(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 1;
    m = m / 10;
    while (m != 0) begin
      n++;
      m = m / 10;
    end
    return n;
  endfunction

  localparam int BCD_DIGITS = dec_digits(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int PAD_W      = 4 * (NUM_DIGITS + BCD_DIGITS + 8);
  localparam int HEX_W      = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPDATE} state_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    case (n)
      4'h0: seg_glyph = 7'b1000000;
      4'h1: seg_glyph = 7'b1111001;
      4'h2: seg_glyph = 7'b0100100;
      4'h3: seg_glyph = 7'b0110000;
      4'h4: seg_glyph = 7'b0011001;
      4'h5: seg_glyph = 7'b0010010;
      4'h6: seg_glyph = 7'b0000010;
      4'h7: seg_glyph = 7'b1111000;
      4'h8: seg_glyph = 7'b0000000;
      4'h9: seg_glyph = 7'b0010000;
      4'hA: seg_glyph = 7'b0001000;
      4'hB: seg_glyph = 7'b0000011;
      4'hC: seg_glyph = 7'b1000110;
      4'hD: seg_glyph = 7'b0100001;
      4'hE: seg_glyph = 7'b0000110;
      default: seg_glyph = 7'b0001110;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    val_q, val_d;
  logic                 mode_q, mode_d;
  logic                 blz_q, blz_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HEX_W-1:0]     hex_q, hex_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic                 unused_bcd_msb;
  logic [PAD_W-1:0]     val_pad, bcd_pad;
  logic                 ovf_calc;
  logic                 lead;
  logic [3:0]           nib;
  logic [HEX_W-1:0]     glyph_vec;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Digit selection, overflow detection, leading-zero blanking and glyph lookup for the latched value.
  always_comb begin
    val_pad   = PAD_W'(val_q);
    bcd_pad   = PAD_W'(bcd_q);
    ovf_calc  = mode_q ? (|(bcd_pad >> (4*NUM_DIGITS))) : (|(val_pad >> (4*NUM_DIGITS)));
    lead      = blz_q;
    nib       = 4'd0;
    glyph_vec = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = mode_q ? bcd_pad[4*i +: 4] : val_pad[4*i +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (ovf_calc)               glyph_vec[7*i +: 7] = 7'b0111111;
      else if (lead && (i != 0))  glyph_vec[7*i +: 7] = 7'b1111111;
      else                        glyph_vec[7*i +: 7] = seg_glyph(nib);
    end
  end

  // Next-state logic for the IDLE -> (CONV) -> UPDATE sequence.
  always_comb begin
    state_d        = state_q;
    val_d          = val_q;
    mode_d         = mode_q;
    blz_d          = blz_q;
    bcd_d          = bcd_q;
    cnt_d          = cnt_q;
    hex_d          = hex_q;
    ovf_d          = ovf_q;
    busy_d         = busy_q;
    unused_bcd_msb = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          val_d  = value;
          mode_d = mode;
          blz_d  = blank_lz;
          busy_d = 1'b1;
          if (mode) begin
            state_d = S_CONV;
            bcd_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_UPDATE;
          end
        end
      end
      S_CONV: begin
        {unused_bcd_msb, bcd_d} = {bcd_adj, val_q[DATA_W-1]};
        val_d = val_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        hex_d   = glyph_vec;
        ovf_d   = ovf_calc;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control FSM and datapath registers; reset aborts any conversion and blanks the display.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      mode_q  <= 1'b0;
      blz_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= '1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      blz_q   <= blz_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;

`ifdef SEVENSEG_BLINK_EN
  localparam int BCNT_W = $clog2(BLINK_DIV);

  logic [BCNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_hide_q, blink_hide_d;

  // Blink phase counter: runs only while blink is high, restarts visible when blink drops.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    blink_hide_d = blink_hide_q;
    if (!blink) begin
      blink_cnt_d  = '0;
      blink_hide_d = 1'b0;
    end else if (blink_cnt_q == BCNT_W'(BLINK_DIV - 1)) begin
      blink_cnt_d  = '0;
      blink_hide_d = ~blink_hide_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BCNT_W'(1);
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blink_cnt_q  <= '0;
      blink_hide_q <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      blink_hide_q <= blink_hide_d;
    end
  end

  // The phase only goes hidden while blink is high, so masking on it alone gives a registered reveal.
  assign HEX = blink_hide_q ? {HEX_W{1'b1}} : hex_q;
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = blink;
  assign HEX          = hex_q;
`endif

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Randomised bench for seven_seg_display_ctrl against an arithmetic reference model.
// Checks reset, hex/decimal rendering, latency, load-while-busy, overflow, blanking and blink.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_seven_seg_display_ctrl;

  localparam int ND  = 4;
  localparam int DW  = 16;
  localparam int BDV = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   value;
  logic            mode;
  logic            blank_lz;
  logic            load;
  logic            blink;
  logic            busy;
  logic            overflow;
  logic [7*ND-1:0] HEX;

  int total = 0;
  int bad   = 0;
  logic [7*ND-1:0] last_hex;
  logic            last_ovf;
  logic [6:0]      glyph_tab [16];

  seven_seg_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(BDV)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .value    (value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .load     (load),
    .blink    (blink),
    .busy     (busy),
    .overflow (overflow),
    .HEX      (HEX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ovf(input int unsigned v, input logic m);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * (m ? 10 : 16);
    return longint'(v) >= lim;
  endfunction

  function automatic logic [7*ND-1:0] model_hex(input int unsigned v, input logic m, input logic b);
    int unsigned d [ND];
    int unsigned p;
    int msd;
    logic [7*ND-1:0] r;
    if (model_ovf(v, m)) return {ND{7'b0111111}};
    p   = 1;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = m ? (v / p) % 10 : (v >> (4*i)) & 15;
      p    = p * 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = (b && i > msd) ? 7'b1111111 : glyph_tab[d[i]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one load (DUT must be idle), check busy, latency and the rendered result.
  task automatic run_load(input string tag, input int unsigned v, input logic m, input logic b);
    int n;
    value    = DW'(v);
    mode     = m;
    blank_lz = b;
    load     = 1'b1;
    step();
    load = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, m ? DW + 1 : 1);
    last_hex = model_hex(v, m, b);
    last_ovf = model_ovf(v, m);
    chk({tag, "_hex"}, HEX, last_hex);
    chk({tag, "_ovf"}, overflow, last_ovf);
  endtask

  initial begin
    int n;
    glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b1; value = '0; mode = 1'b0; blank_lz = 1'b0; load = 1'b0; blink = 1'b0;
    repeat (2) step();
    chk("reset_hex", HEX, 28'hFFFFFFF);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    reset = 1'b0;
    step();

    // Reset in the middle of a decimal conversion.
    value = 16'd999; mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    chk("conv_busy", busy, 1'b1);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("abort_hex", HEX, 28'hFFFFFFF);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    repeat (25) step();
    chk("abort_no_update", HEX, 28'hFFFFFFF);
    chk("abort_idle", busy, 1'b0);

    // Directed cases.
    run_load("beef",   16'hBEEF, 1'b0, 1'b0);
    chk("beef_glyphs", HEX, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
    run_load("d1234",  1234, 1'b1, 1'b1);
    run_load("d7",     7, 1'b1, 1'b1);
    chk("d7_glyphs", HEX, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
    run_load("d12345", 12345, 1'b1, 1'b0);
    chk("d12345_dash", HEX, {4{7'b0111111}});
    run_load("h0",     0, 1'b0, 1'b1);
    chk("h0_glyphs", HEX, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    run_load("d0",     0, 1'b1, 1'b1);
    run_load("d65535", 65535, 1'b1, 1'b1);
    run_load("d9999",  9999, 1'b1, 1'b1);
    run_load("d10000", 10000, 1'b1, 1'b1);

    // A load arriving mid-conversion is dropped.
    value = 16'd42; mode = 1'b1; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    value = 16'd5555; mode = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("drop_latency", n, DW + 1 - 3);
    last_hex = model_hex(42, 1'b1, 1'b1);
    last_ovf = 1'b0;
    chk("drop_hex", HEX, last_hex);
    step();
    chk("drop_no_queue", busy, 1'b0);

    // Randomised back-to-back loads.
    for (int t = 0; t < 40; t++) begin
      int unsigned v;
      case ($urandom_range(0, 2))
        0:       v = $urandom_range(0, 65535);
        1:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, 300);
      endcase
      run_load("rnd", v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Outputs hold regardless of the value input.
    value = DW'($urandom_range(0, 65535));
    repeat (5) step();
    chk("hold_hex", HEX, last_hex);
    chk("hold_ovf", overflow, last_ovf);

    // Blink behaviour.
    blink = 1'b1;
`ifdef SEVENSEG_BLINK_EN
    for (int e = 1; e <= 14; e++) begin
      step();
      chk("blink_phase", HEX, (((e / BDV) % 2) == 1) ? {7*ND{1'b1}} : last_hex);
    end
    blink = 1'b0;
    step();
    chk("blink_release", HEX, last_hex);
`else
    for (int e = 1; e <= 14; e++) begin
      step();
      chk("blink_ignored", HEX, last_hex);
    end
    blink = 1'b0;
    step();
    chk("blink_release", HEX, last_hex);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
